sd_data_xfer_ctrl: RTL
======================

Name: sd_data_xfer_ctrl

Overview:
Multi-block transfer sequencer that drives the SD data serial host's control interface (start_dat, ack_transfer) on behalf of the DMA/register layer. It issues one block transfer at a time and waits for completion. It acknowledges each block, checks crc_ok, retries failed blocks, enforces a per-block timeout and handles software abort. It sits between the controller register file and the data serial host, in the sd_clk domain.

Parameters:
TIMEOUT_W, 24, width of per-block timeout counter.
RETRY_MAX, 2, retries allowed per block after a CRC failure (0 = no retry).
GAP_CYCLES, 2, idle sd_clk cycles inserted between consecutive blocks (at least 1).
BLK_CNT_W, 16, width of block count.

Ports:
sd_clk  in  1  SD clock; all logic on posedge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  transfer request.
req_ready  out  1  high only in IDLE; request accepted when valid&ready.
req_write  in  1  1 = write (start_dat 01), 0 = read (start_dat 10).
req_blocks  in  BLK_CNT_W  number of blocks.
req_timeout  in  TIMEOUT_W  per-block timeout in sd_clk cycles.
abort_req  in  1  software abort, level.
start_dat  out  2  to serial host: 00 none, 01 write, 10 read, 11 abort.
ack_transfer  out  1  to serial host: block acknowledge.
busy_n  in  1  from serial host; 0 = host active.
transm_complete  in  1  from serial host.
crc_ok  in  1  from serial host; valid while transm_complete=1.
blk_done  out  1  one-cycle pulse per block that completes with good CRC.
blocks_left  out  BLK_CNT_W  remaining blocks.
done  out  1  one-cycle pulse at end of request.
status  out  2  valid at done, held until the next accept: 00 ok, 01 crc error, 10 timeout, 11 aborted.

Behaviour:
- Reset values: req_ready=1 once in IDLE, start_dat=00, ack_transfer=0, blk_done=0, done=0, blocks_left=0, status=00. State=IDLE; all counters 0.
- States: IDLE, START, RUN, ACK, GAP, ABORT, FIN.
- IDLE: on accept, latch req_write, req_timeout and blocks_left=req_blocks, then go to START. If req_blocks=0, go directly to FIN with status 00 and issue no start_dat.
- START: drive start_dat=01/10 and load the timeout counter. Hold start_dat until busy_n=0 is sampled, then go to RUN and set start_dat=00.
- RUN: the timeout counter decrements every cycle from START onward.
  - transm_complete=1 -> capture crc_ok, go to ACK.
  - Counter reaches 0 before that -> status=10, go to ABORT.
- ACK: hold ack_transfer=1 until transm_complete=0 and busy_n=1 are both sampled, then drop ack_transfer.
  - Captured crc_ok=1: pulse blk_done, decrement blocks_left, clear retry count. Go to FIN if blocks_left becomes 0, else GAP.
  - Captured crc_ok=0 and retry count < RETRY_MAX: increment retry count and go to GAP; blocks_left is unchanged, so the same block is reissued.
  - Otherwise: status=01, go to FIN.
- GAP: stay GAP_CYCLES cycles with start_dat=00, then go to START.
- ABORT: drive start_dat=11 and ack_transfer=1 until busy_n=1 is sampled, then go to FIN. This covers host abort from data states and exit from busy/read states via ack.
- abort_req sampled high in START, RUN or GAP: status=11, go to ABORT. Abort has priority over a same-cycle transm_complete or timeout. abort_req is ignored in IDLE, ACK and FIN.
- FIN: pulse done for one cycle, then go to IDLE. status holds its value.
- start_dat and ack_transfer are registered outputs, and are never both nonzero except in ABORT.
- Reset mid-transfer immediately returns all outputs to their reset values. The host is reset by the same rst.

Test Plan:
- Write, req_blocks=3, host model completes each block 1100 cycles after start with crc_ok=1 -> three blk_done pulses; blocks_left 3→2→1→0; start_dat=01 observed three times with at least 2 idle cycles between them; done with status=00.
- Read, req_blocks=1, crc_ok=0 on the first two attempts and 1 on the third, RETRY_MAX=2 -> three start_dat=10 issues, one blk_done, status=00.
- Read, req_blocks=2, crc_ok=0 on three consecutive attempts of block 1 -> after the third attempt status=01, done, blocks_left=2, no further start_dat.
- Write, req_timeout=500, host never asserts transm_complete -> at cycle 500 start_dat=11 and ack_transfer=1 until busy_n=1, then done with status=10.
- abort_req raised 200 cycles into a read block, coincident with transm_complete -> abort wins; start_dat=11; status=11; blk_done not pulsed.
- req_blocks=0 -> no start_dat activity; done 2 cycles after accept with status=00. Also assert rst mid-RUN -> all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/sd_data_xfer_ctrl.sv
// Multi-block transfer sequencer for the SD data serial host: issues one block at
// a time, acknowledges completion, retries CRC failures, enforces timeout and abort.
module sd_data_xfer_ctrl #(
  parameter int TIMEOUT_W  = 24,
  parameter int RETRY_MAX  = 2,
  parameter int GAP_CYCLES = 2,
  parameter int BLK_CNT_W  = 16
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BLK_CNT_W-1:0] req_blocks,
  input  logic [TIMEOUT_W-1:0] req_timeout,
  input  logic                 abort_req,
  output logic [1:0]           start_dat,
  output logic                 ack_transfer,
  input  logic                 busy_n,
  input  logic                 transm_complete,
  input  logic                 crc_ok,
  output logic                 blk_done,
  output logic [BLK_CNT_W-1:0] blocks_left,
  output logic                 done,
  output logic [1:0]           status
);

  typedef enum logic [2:0] {IDLE, START, RUN, ACK, GAP, ABORT, FIN} state_t;

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_CRC   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [TIMEOUT_W-1:0]   tmo_len_q, tmo_len_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic                   crc_q, crc_d;
  logic [BLK_CNT_W-1:0]   blocks_left_q, blocks_left_d;
  logic [1:0]             status_q, status_d;
  logic [1:0]             start_dat_q, start_dat_d;
  logic                   ack_q, ack_d;
  logic                   blk_done_q, blk_done_d;
  logic                   done_q, done_d;

  logic accept, tmo_hit, ack_exit, retry_avail;

  assign req_ready    = (state_q == IDLE);
  assign accept       = req_valid && req_ready;
  // The counter "reaches 0" on the cycle it would decrement from 1 (or is already 0).
  assign tmo_hit      = (tmo_q <= TIMEOUT_W'(1));
  assign ack_exit     = !transm_complete && busy_n;
  assign retry_avail  = (retry_q < RW'(RETRY_MAX));

  assign start_dat    = start_dat_q;
  assign ack_transfer = ack_q;
  assign blk_done     = blk_done_q;
  assign blocks_left  = blocks_left_q;
  assign done         = done_q;
  assign status       = status_q;

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Abort outranks completion, which outranks timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (req_blocks == '0) ? FIN : START;
      START: begin
        if (abort_req)    state_d = ABORT;
        else if (tmo_hit) state_d = ABORT;
        else if (!busy_n) state_d = RUN;
      end
      RUN: begin
        if (abort_req)            state_d = ABORT;
        else if (transm_complete) state_d = ACK;
        else if (tmo_hit)         state_d = ABORT;
      end
      ACK: begin
        if (ack_exit) begin
          if (crc_q)            state_d = (blocks_left_q == BLK_CNT_W'(1)) ? FIN : GAP;
          else if (retry_avail) state_d = GAP;
          else                  state_d = FIN;
        end
      end
      GAP: begin
        if (abort_req)          state_d = ABORT;
        else if (gap_q == '0)   state_d = START;
      end
      ABORT: if (busy_n) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    write_d       = write_q;
    tmo_len_d     = tmo_len_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    gap_d         = gap_q;
    crc_d         = crc_q;
    blocks_left_d = blocks_left_q;
    status_d      = status_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d       = req_write;
          tmo_len_d     = req_timeout;
          blocks_left_d = req_blocks;
          status_d      = ST_OK;
          retry_d       = '0;
        end
      end
      START, RUN: begin
        tmo_d = (tmo_q == '0) ? '0 : tmo_q - TIMEOUT_W'(1);
        if (state_d == ACK) crc_d = crc_ok;
      end
      ACK: begin
        if (ack_exit) begin
          if (crc_q) begin
            blocks_left_d = blocks_left_q - BLK_CNT_W'(1);
            retry_d       = '0;
          end else if (retry_avail) begin
            retry_d = retry_q + RW'(1);
          end else begin
            status_d = ST_CRC;
          end
        end
      end
      GAP: if (gap_q != '0) gap_d = gap_q - GW'(1);
      default: ;
    endcase
    // Every block attempt, including retries, gets a fresh timeout budget.
    if (state_d == START && state_q != START)
      tmo_d = (state_q == IDLE) ? req_timeout : tmo_len_q;
    if (state_d == GAP && state_q != GAP)
      gap_d = GW'(GAP_CYCLES - 1);
    if (state_d == ABORT && state_q != ABORT)
      status_d = abort_req ? ST_ABORT : ST_TMO;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    start_dat_d = 2'b00;
    ack_d       = 1'b0;
    case (state_d)
      START: start_dat_d = write_d ? 2'b01 : 2'b10;
      ACK:   ack_d = 1'b1;
      ABORT: begin
        start_dat_d = 2'b11;
        ack_d       = 1'b1;
      end
      default: ;
    endcase
    blk_done_d = (state_q == ACK) && ack_exit && crc_q;
    done_d     = (state_q == FIN);
  end

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      write_q       <= 1'b0;
      tmo_len_q     <= '0;
      tmo_q         <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
      crc_q         <= 1'b0;
      blocks_left_q <= '0;
      status_q      <= ST_OK;
      start_dat_q   <= 2'b00;
      ack_q         <= 1'b0;
      blk_done_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      write_q       <= write_d;
      tmo_len_q     <= tmo_len_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      gap_q         <= gap_d;
      crc_q         <= crc_d;
      blocks_left_q <= blocks_left_d;
      status_q      <= status_d;
      start_dat_q   <= start_dat_d;
      ack_q         <= ack_d;
      blk_done_q    <= blk_done_d;
      done_q        <= done_d;
    end
  end

endmodule
